// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding and output-arbiter state.
// Used by the router, the input buffers and the output arbiters.
package noc_pkg;

  localparam int unsigned FLIT_W        = 16;
  localparam int unsigned FLIT_TYPE_MSB = FLIT_W - 1;

  typedef enum logic [1:0] {
    FlitBody   = 2'b00,
    FlitHead   = 2'b01,
    FlitTail   = 2'b10,
    FlitSingle = 2'b11
  } flit_type_e;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i, wrapping
// modulo NUM_REQ. Produces a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IdxW'((int'(ptr_i) + k) % int'(NUM_REQ));
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Per-output-port switch allocator: wormhole packet locking, packet-granular
// round-robin fairness and downstream credit tracking with sticky overflow flag.
module noc_output_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned FLIT_W  = 16,
  parameter int unsigned CREDITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*FLIT_W-1:0] flit_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [FLIT_W-1:0]         data_o,
  output logic                      valid_o,
  input  logic                      credit_i,
  output logic                      err_o
);

  import noc_pkg::*;

  localparam int unsigned     IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0]      CntInit = 4'(CREDITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [FLIT_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [FLIT_W-1:0] flits     [NUM_REQ];
  flit_type_e        flit_type [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IdxW-1:0]    win_idx;
  logic               grant_any;
  flit_type_e         win_type;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      flits[i]     = flit_i[i*FLIT_W +: FLIT_W];
      flit_type[i] = flit_type_e'(flits[i][FLIT_W-1 -: 2]);
    end
  end

  // Idle: only packet starts compete. Locked: the owner alone, whatever it sends.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state_q == StIdle) begin
        elig[i] = req_i[i] && (flit_type[i] == FlitHead || flit_type[i] == FlitSingle);
      end else begin
        elig[i] = req_i[i] && (IdxW'(i) == owner_q);
      end
    end
  end

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IdxW   (IdxW)
  ) u_rr_arbiter (
    .req_i(elig),
    .ptr_i(rr_ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(win_idx)
  );

  // Grant only on credits already held; a same-cycle credit_i does not count.
  assign grant_any = !reset && (cnt_q != 4'd0) && (|arb_gnt);
  assign gnt_o     = grant_any ? arb_gnt : '0;
  assign win_type  = flit_type[win_idx];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = grant_any;
    err_d    = err_q;

    if (grant_any) begin
      data_d   = flits[win_idx];
      rr_ptr_d = (win_idx == LastIdx) ? '0 : win_idx + 1'b1;
      case (state_q)
        StIdle: begin
          if (win_type == FlitHead) begin
            state_d = StLocked;
            owner_d = win_idx;
          end
        end
        StLocked: begin
          if (win_type == FlitTail) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (grant_any && !credit_i) begin
      cnt_d = cnt_q - 4'd1;
    end else if (!grant_any && credit_i) begin
      if (cnt_q == CntInit) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= CntInit;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed self-checking bench for noc_output_arbiter (NUM_REQ=4, FLIT_W=16, CREDITS=4).
module tb_noc_output_arbiter;

  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_i;
  logic [63:0] flit_i;
  logic [3:0]  gnt_o;
  logic [15:0] data_o;
  logic        valid_o;
  logic        credit_i;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_output_arbiter #(
    .NUM_REQ(4),
    .FLIT_W (16),
    .CREDITS(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req_i),
    .flit_i  (flit_i),
    .gnt_o   (gnt_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .credit_i(credit_i),
    .err_o   (err_o)
  );

  task automatic do_reset();
    reset    = 1'b1;
    req_i    = '0;
    flit_i   = '0;
    credit_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    credit_i = 1'b0;
    flit_i   = '0;
    flit_i[15:0] = 16'hC0AA;
    req_i    = 4'b0001;
    @(negedge clk);
    #1;
    checks++;
    if (gnt_o !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt: got %b expected %b", gnt_o, 4'b0000);
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected %b", valid_o, 1'b0);
    end
    checks++;
    if (data_o !== 16'h0000) begin
      errors++; $display("FAIL reset_data: got %h expected %h", data_o, 16'h0000);
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b expected %b", err_o, 1'b0);
    end
    checks++;
    if (dut.cnt_q !== 4'd4) begin
      errors++; $display("FAIL reset_cnt: got %0d expected %0d", dut.cnt_q, 4);
    end
    checks++;
    if (dut.state_q !== StIdle) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, StIdle);
    end
    req_i = '0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    flit_i[15:0] = 16'hC0AA;
    req_i        = 4'b0001;
    #1;
    checks++;
    if (gnt_o !== 4'b0001) begin
      errors++; $display("FAIL single_gnt: got %b expected %b", gnt_o, 4'b0001);
    end
    @(negedge clk);
    req_i = '0;
    checks++;
    if (valid_o !== 1'b1 || data_o !== 16'hC0AA) begin
      errors++;
      $display("FAIL single_out: got valid %b data %h expected valid 1 data c0aa", valid_o, data_o);
    end
    checks++;
    if (dut.cnt_q !== 4'd3) begin
      errors++; $display("FAIL single_cnt: got %0d expected %0d", dut.cnt_q, 3);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || data_o !== 16'hC0AA) begin
      errors++;
      $display("FAIL single_hold: got valid %b data %h expected valid 0 data c0aa", valid_o, data_o);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_gnt  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
    logic [15:0] exp_data [4] = '{16'hC001, 16'hC002, 16'hC003, 16'hC001};
    do_reset();
    flit_i[15:0]  = 16'hC001;
    flit_i[31:16] = 16'hC002;
    flit_i[47:32] = 16'hC003;
    req_i         = 4'b0111;
    credit_i      = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (gnt_o !== exp_gnt[k]) begin
        errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt_o, exp_gnt[k]);
      end
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b1 || data_o !== exp_data[k]) begin
        errors++;
        $display("FAIL rr_data[%0d]: got valid %b data %h expected valid 1 data %h",
                 k, valid_o, data_o, exp_data[k]);
      end
    end
    req_i    = '0;
    credit_i = 1'b0;
    checks++;
    if (dut.cnt_q !== 4'd4 || err_o !== 1'b0) begin
      errors++; $display("FAIL rr_cnt: got cnt %0d err %b expected cnt 4 err 0", dut.cnt_q, err_o);
    end
  endtask

  task automatic test_wormhole();
    logic [15:0] f1       [5] = '{16'h4011, 16'h0111, 16'h0112, 16'h8113, 16'h0000};
    logic [3:0]  reqs     [5] = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0100};
    logic [3:0]  exp_gnt  [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    logic [15:0] exp_data [5] = '{16'h4011, 16'h0111, 16'h0112, 16'h8113, 16'h4022};
    do_reset();
    flit_i[47:32] = 16'h4022;
    credit_i      = 1'b1;
    for (int k = 0; k < 5; k++) begin
      flit_i[31:16] = f1[k];
      req_i         = reqs[k];
      #1;
      checks++;
      if (gnt_o !== exp_gnt[k]) begin
        errors++; $display("FAIL worm_gnt[%0d]: got %b expected %b", k, gnt_o, exp_gnt[k]);
      end
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b1 || data_o !== exp_data[k]) begin
        errors++;
        $display("FAIL worm_data[%0d]: got valid %b data %h expected valid 1 data %h",
                 k, valid_o, data_o, exp_data[k]);
      end
    end
    req_i    = '0;
    credit_i = 1'b0;
  endtask

  task automatic test_credit_stall();
    do_reset();
    flit_i[15:0] = 16'hC0B0;
    req_i        = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (gnt_o !== ((k < 4) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL stall_gnt[%0d]: got %b expected %b", k, gnt_o,
                 (k < 4) ? 4'b0001 : 4'b0000);
      end
      @(negedge clk);
    end
    checks++;
    if (dut.cnt_q !== 4'd0) begin
      errors++; $display("FAIL stall_cnt: got %0d expected %0d", dut.cnt_q, 0);
    end
    credit_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 4'b0000) begin
      errors++; $display("FAIL stall_same_cycle: got %b expected %b", gnt_o, 4'b0000);
    end
    @(negedge clk);
    credit_i = 1'b0;
    #1;
    checks++;
    if (gnt_o !== 4'b0001) begin
      errors++; $display("FAIL stall_resume: got %b expected %b", gnt_o, 4'b0001);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 16'hC0B0) begin
      errors++;
      $display("FAIL stall_out: got valid %b data %h expected valid 1 data c0b0", valid_o, data_o);
    end
    #1;
    checks++;
    if (gnt_o !== 4'b0000) begin
      errors++; $display("FAIL stall_again: got %b expected %b", gnt_o, 4'b0000);
    end
    req_i = '0;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    do_reset();
    credit_i = 1'b1;
    @(negedge clk);
    credit_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || dut.cnt_q !== 4'd4) begin
      errors++; $display("FAIL ovf_set: got err %b cnt %0d expected err 1 cnt 4", err_o, dut.cnt_q);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b expected %b", err_o, 1'b1);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    credit_i     = 1'b1;
    flit_i[15:0] = 16'h4100;
    req_i        = 4'b0001;
    #1;
    checks++;
    if (gnt_o !== 4'b0001) begin
      errors++; $display("FAIL mid_head: got %b expected %b", gnt_o, 4'b0001);
    end
    @(negedge clk);
    flit_i[15:0] = 16'h0101;
    #1;
    checks++;
    if (gnt_o !== 4'b0001) begin
      errors++; $display("FAIL mid_body: got %b expected %b", gnt_o, 4'b0001);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 4'b0000 || dut.state_q !== StIdle) begin
      errors++;
      $display("FAIL mid_async: got gnt %b state %0d expected gnt 0000 state 0", gnt_o, dut.state_q);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || dut.cnt_q !== 4'd4 || dut.state_q !== StIdle) begin
      errors++;
      $display("FAIL mid_state: got valid %b cnt %0d state %0d expected valid 0 cnt 4 state 0",
               valid_o, dut.cnt_q, dut.state_q);
    end
    reset    = 1'b0;
    credit_i = 1'b0;
    #1;
    checks++;
    if (gnt_o !== 4'b0000) begin
      errors++; $display("FAIL mid_orphan_body: got %b expected %b", gnt_o, 4'b0000);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL mid_valid: got %b expected %b", valid_o, 1'b0);
    end
    req_i = '0;
  endtask

  initial begin
    reset    = 1'b1;
    req_i    = '0;
    flit_i   = '0;
    credit_i = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wormhole();
    test_credit_stall();
    test_overflow();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
